// File: rtl/tft_timing_gen.sv
// RGB TFT timing generator with programmable porches and sync polarity.
// Drives HS/VS/DE, requests upstream pixels and can substitute test patterns.
module tft_timing_gen #(
    parameter int DATA_W   = 16,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = 11
) (
    input  logic              clk33m,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] solid_color,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_req,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic              frame_start,
    output logic              line_start,
    output logic [DATA_W-1:0] tft_rgb,
    output logic              tft_hs,
    output logic              tft_vs,
    output logic              tft_de,
    output logic              tft_clk,
    output logic              tft_bl
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SY    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SY    = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_A0    = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_A0    = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic             HS_ON   = 1'(HS_POL);
    localparam logic             VS_ON   = 1'(VS_POL);

    logic              running;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              h_last;
    logic              v_last;
    logic              h_act;
    logic              v_act;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] solid_q;
    logic [2:0]        bar_idx;
    logic [DATA_W-1:0] pix_sel;

    function automatic logic [DATA_W-1:0] fit(input logic [15:0] c);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = c[i % 16];
        end
        return r;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        unique case (idx)
            3'd0: c = 16'hFFFF;
            3'd1: c = 16'hFFE0;
            3'd2: c = 16'h07FF;
            3'd3: c = 16'h07E0;
            3'd4: c = 16'hF81F;
            3'd5: c = 16'hF800;
            3'd6: c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign h_act  = (h_cnt >= H_A0) && ((h_cnt - H_A0) < H_ACT_C);
    assign v_act  = (v_cnt >= V_A0) && ((v_cnt - V_A0) < V_ACT_C);

    assign data_req    = running && h_act && v_act;
    assign pix_x       = data_req ? (h_cnt - H_A0) : '0;
    assign pix_y       = data_req ? (v_cnt - V_A0) : '0;
    assign line_start  = running && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);
    assign tft_clk     = clk33m;

    // Run flag and raster counters; a stop request waits for the frame end.
    always_ff @(posedge clk33m or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (!running) begin
            running <= en;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            if (h_last && v_last && !en) begin
                running <= 1'b0;
            end
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + ONE;
            end else begin
                h_cnt <= h_cnt + ONE;
            end
        end
    end

    // Pattern controls only change on a frame boundary.
    always_ff @(posedge clk33m or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 2'd0;
            solid_q <= '0;
        end else if (frame_start) begin
            mode_q  <= mode;
            solid_q <= solid_color;
        end
    end

    // Pixel source selection for the current request.
    always_comb begin
        bar_idx = 3'(({pix_x, 3'b000}) / (CNT_W + 3)'(H_ACTIVE));
        pix_sel = '0;
        unique case (mode_q)
            2'd0: pix_sel = data_in;
            2'd1: pix_sel = fit(bar_color(bar_idx));
            2'd2: pix_sel = fit((pix_x[5] ^ pix_y[5]) ? 16'hFFFF : 16'h0000);
            default: pix_sel = solid_q;
        endcase
    end

    // Panel pins, one cycle behind the counters.
    always_ff @(posedge clk33m or negedge rst_n) begin
        if (!rst_n) begin
            tft_hs  <= ~HS_ON;
            tft_vs  <= ~VS_ON;
            tft_de  <= 1'b0;
            tft_rgb <= '0;
            tft_bl  <= 1'b0;
        end else begin
            tft_hs  <= (running && h_cnt < H_SY) ? HS_ON : ~HS_ON;
            tft_vs  <= (running && v_cnt < V_SY) ? VS_ON : ~VS_ON;
            tft_de  <= data_req;
            tft_rgb <= data_req ? pix_sel : '0;
            tft_bl  <= running;
        end
    end

endmodule

// File: tb/tb_tft_timing_gen.sv
// Scoreboard bench for tft_timing_gen on a reduced raster.
// Checks live outputs, sync/DE widths, captured frames and stop/reset.
module tb_tft_timing_gen;

    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSW = 8;
    localparam int HBP = 6;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int HT  = HSW + HBP + HA + HFP;
    localparam int VT  = VSW + VBP + VA + VFP;
    localparam int NV  = 23;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct packed {
        logic       hs_act;
        logic       vs_act;
        logic       de;
        logic [15:0] rgb;
        logic       bl;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] f;
    } exp_t;

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [15:0] px;
    } vec_t;

    logic        clk33m = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_color = 16'h0;
    logic [15:0] data_in;

    logic        data_req, frame_start, line_start;
    logic [10:0] pix_x, pix_y;
    logic [15:0] tft_rgb;
    logic        tft_hs, tft_vs, tft_de, tft_clk, tft_bl;

    logic        req1, fs1, ls1, hs1, vs1, de1, clk1, bl1;
    logic [10:0] px1, py1;
    logic [15:0] rgb1;

    int checks = 0;
    int errors = 0;

    int   mh = 0, mv = 0, fcnt = 0;
    logic mrun = 1'b0;
    logic [1:0]  mmode = 2'd0;
    logic [15:0] msolid = 16'h0;
    logic mreq;
    int   mx, my;

    exp_t sb[$];
    exp_t pe, ce;
    logic st;
    logic [15:0] fb [4][VA][HA];
    vec_t vecs [NV];
    int hs_run = 0, vs_run = 0, de_run = 0, fs_cnt = 0;

    tft_timing_gen #(
        .DATA_W(16), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .CNT_W(11)
    ) u_dut (
        .clk33m(clk33m), .rst_n(rst_n), .en(en), .mode(mode),
        .solid_color(solid_color), .data_in(data_in),
        .data_req(data_req), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_start(line_start),
        .tft_rgb(tft_rgb), .tft_hs(tft_hs), .tft_vs(tft_vs),
        .tft_de(tft_de), .tft_clk(tft_clk), .tft_bl(tft_bl)
    );

    tft_timing_gen #(
        .DATA_W(16), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1), .VS_POL(1), .CNT_W(11)
    ) u_pol (
        .clk33m(clk33m), .rst_n(rst_n), .en(en), .mode(mode),
        .solid_color(solid_color), .data_in(data_in),
        .data_req(req1), .pix_x(px1), .pix_y(py1),
        .frame_start(fs1), .line_start(ls1),
        .tft_rgb(rgb1), .tft_hs(hs1), .tft_vs(vs1),
        .tft_de(de1), .tft_clk(clk1), .tft_bl(bl1)
    );

    always #5 clk33m = ~clk33m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] exp_pix(input logic [1:0] m, input int x, input int y,
                                            input logic [15:0] din, input logic [15:0] sol);
        logic [15:0] r;
        case (m)
            2'd0: r = din;
            2'd1: r = BARS[(x * 8) / HA];
            2'd2: r = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: r = sol;
        endcase
        return r;
    endfunction

    // Reference raster position and upstream source stimulus
    always_comb begin
        mreq = mrun && mh >= HSW + HBP && mh < HSW + HBP + HA
                    && mv >= VSW + VBP && mv < VSW + VBP + VA;
        mx = 0;
        my = 0;
        if (mreq) begin
            mx = mh - (HSW + HBP);
            my = mv - (VSW + VBP);
        end
        data_in = {5'(my), 11'(mx)};
    end

    // Reference model: push the expected registered outputs on each edge
    always @(posedge clk33m or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            pe = '0;
            sb.push_back(pe);
            mrun   <= 1'b0;
            mh     <= 0;
            mv     <= 0;
            mmode  <= 2'd0;
            msolid <= 16'h0;
        end else begin
            st = mrun && mh == 0 && mv == 0;
            pe.hs_act = mrun && mh < HSW;
            pe.vs_act = mrun && mv < VSW;
            pe.de     = mreq;
            pe.rgb    = mreq ? exp_pix(mmode, mx, my, data_in, msolid) : 16'h0;
            pe.bl     = mrun;
            pe.x      = 8'(mx);
            pe.y      = 8'(my);
            pe.f      = 4'(st ? fcnt : fcnt - 1);
            sb.push_back(pe);
            if (st) begin
                mmode  <= mode;
                msolid <= solid_color;
                fcnt   <= fcnt + 1;
            end
            if (!mrun) begin
                mrun <= en;
            end else begin
                if (mh == HT - 1 && mv == VT - 1 && !en) mrun <= 1'b0;
                if (mh == HT - 1) begin
                    mh <= 0;
                    mv <= (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh <= mh + 1;
                end
            end
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk33m) begin
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            chk("out", {tft_hs, tft_vs, tft_de, tft_rgb, tft_bl},
                {~ce.hs_act, ~ce.vs_act, ce.de, ce.rgb, ce.bl});
            chk("pol1_sync", {hs1, vs1}, {ce.hs_act, ce.vs_act});
            if (ce.de && ce.f < 4) fb[ce.f][ce.y][ce.x] = tft_rgb;
        end
        chk("req", {data_req, pix_x, pix_y, frame_start, line_start},
            {mreq, 11'(mx), 11'(my), mrun && mh == 0 && mv == 0, mrun && mh == 0});
        chk("tft_clk", tft_clk, clk33m);
        if (frame_start) fs_cnt++;
        if (!rst_n) begin
            hs_run = 0;
            vs_run = 0;
            de_run = 0;
        end else begin
            if (!tft_hs) hs_run++;
            else if (hs_run > 0) begin chk("hs_width", hs_run, HSW); hs_run = 0; end
            if (!tft_vs) vs_run++;
            else if (vs_run > 0) begin chk("vs_width", vs_run, VSW * HT); vs_run = 0; end
            if (tft_de) de_run++;
            else if (de_run > 0) begin chk("de_width", de_run, HA); de_run = 0; end
        end
    end

    task automatic wait_pos(input int f, input int h, input int v);
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk33m);
            #1;
            if (fcnt == f && mh == h && mv == v) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos: timeout waiting f=%0d h=%0d v=%0d", f, h, v);
    endtask

    initial begin
        int n;
        for (int f = 0; f < 4; f++)
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    fb[f][y][x] = 16'hDEAD;

        vecs[0]  = '{0, 0, 0, 16'h0000};
        vecs[1]  = '{0, 63, 0, 16'h003F};
        vecs[2]  = '{0, 5, 1, 16'h0805};
        vecs[3]  = '{0, 63, 39, 16'h383F};
        vecs[4]  = '{1, 0, 0, 16'hF800};
        vecs[5]  = '{1, 10, 30, 16'hF800};
        vecs[6]  = '{1, 63, 39, 16'hF800};
        vecs[7]  = '{2, 0, 0, 16'hFFFF};
        vecs[8]  = '{2, 7, 3, 16'hFFFF};
        vecs[9]  = '{2, 8, 0, 16'hFFE0};
        vecs[10] = '{2, 16, 10, 16'h07FF};
        vecs[11] = '{2, 24, 1, 16'h07E0};
        vecs[12] = '{2, 32, 2, 16'hF81F};
        vecs[13] = '{2, 40, 5, 16'hF800};
        vecs[14] = '{2, 48, 39, 16'h001F};
        vecs[15] = '{2, 56, 0, 16'h0000};
        vecs[16] = '{2, 63, 39, 16'h0000};
        vecs[17] = '{3, 32, 0, 16'hFFFF};
        vecs[18] = '{3, 32, 32, 16'h0000};
        vecs[19] = '{3, 0, 0, 16'h0000};
        vecs[20] = '{3, 31, 32, 16'hFFFF};
        vecs[21] = '{3, 0, 33, 16'hFFFF};
        vecs[22] = '{3, 63, 39, 16'h0000};

        repeat (3) @(posedge clk33m);
        #1;
        chk("rst_idle", {tft_hs, tft_vs, tft_de, tft_rgb, tft_bl, data_req},
            {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        chk("rst_pol1", {hs1, vs1}, 2'b00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk33m);
        #1;
        en = 1'b1;

        wait_pos(1, 40, 20);
        mode = 2'd3;
        solid_color = 16'hF800;
        wait_pos(2, 40, 20);
        mode = 2'd1;
        solid_color = 16'h001F;
        wait_pos(3, 40, 20);
        mode = 2'd2;
        wait_pos(4, 40, 20);
        en = 1'b0;

        n = 0;
        while (tft_bl !== 1'b0 && n < 5000) begin
            @(posedge clk33m);
            #1;
            n++;
        end
        chk("stop_len", n, (VT - 1 - 20) * HT + (HT - 1 - 40) + 2);
        repeat (20) @(posedge clk33m);
        #1;
        chk("stop_idle", {tft_hs, tft_vs, tft_de, tft_bl, data_req}, 5'b11000);
        chk("frames_a", fs_cnt, 4);

        for (int i = 0; i < NV; i++)
            chk($sformatf("vec%0d", i), fb[vecs[i].f][vecs[i].y][vecs[i].x], vecs[i].px);

        en = 1'b1;
        wait_pos(5, 40, 10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_idle", {tft_hs, tft_vs, tft_de, tft_rgb, tft_bl, data_req, line_start},
            {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        chk("arst_pol1", {hs1, vs1}, 2'b00);
        en = 1'b0;
        repeat (3) @(posedge clk33m);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk33m);
        #1;
        chk("post_rst", {tft_de, tft_bl, data_req}, 3'b000);
        chk("frames_b", fs_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tft_timing_gen.md
Name: tft_timing_gen

Overview:
- Parametrised RGB-interface TFT timing generator with built-in test-pattern source; next generation of our fixed 800x480 controller.
- Generates HS/VS/DE with programmable porches and polarity, plus a pixel-request/coordinate interface to the upstream frame source.
- Can substitute internal patterns for upstream data.
- Sits between the frame buffer/pixel generator and the panel pins.

Parameters:
DATA_W, 16, pixel width (RGB565 at 16; patterns defined for 16, replicated/truncated otherwise)
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch
H_SYNC, 128, HS pulse width
H_BP, 88, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, VS pulse width
V_BP, 33, vertical back porch
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
CNT_W, 11, counter/coordinate width

Ports:
clk33m  in  1  pixel clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  run request
mode  in  2  0 = pass-through, 1 = colour bars, 2 = checker, 3 = solid
solid_color  in  DATA_W  colour for mode 3
data_in  in  DATA_W  upstream pixel, valid in the cycle data_req = 1
data_req  out  1  upstream pixel request
pix_x  out  CNT_W  active-area column for the current request
pix_y  out  CNT_W  active-area row for the current request
frame_start  out  1  one-cycle pulse at h_cnt = 0, v_cnt = 0 while running
line_start  out  1  one-cycle pulse at h_cnt = 0 while running
tft_rgb  out  DATA_W  panel data
tft_hs  out  1  panel HS
tft_vs  out  1  panel VS
tft_de  out  1  panel data enable
tft_clk  out  1  equals clk33m
tft_bl  out  1  backlight enable, equals the running flag, registered

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk33m.
- Totals: H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP; V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP.
- h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Regions, h_cnt: sync is [0, H_SYNC); active is [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE). Vertical regions are analogous.
- Running flag:
  - Cleared by reset.
  - While clear: counters held at 0 and all outputs at idle.
  - Stopped and en = 1: flag sets next cycle; counting starts from 0,0.
  - Running and en = 0: flag clears only at the last cycle of a frame (h = H_TOTAL-1, v = V_TOTAL-1). A frame is never truncated.
- mode and solid_color are latched at frame start only. Mid-frame changes take effect next frame.
- Request path (combinational from counters):
  - data_req = running AND h-active AND v-active.
  - pix_x = h_cnt - (H_SYNC+H_BP); pix_y = v_cnt - (V_SYNC+V_BP). Both are 0 when data_req = 0.
- Output path: all tft_* outputs except tft_clk are registered. Latency is one cycle from counter state.
  - tft_de = data_req delayed by 1 cycle.
  - tft_hs = HS_POL when delayed h-sync region, else ~HS_POL. tft_vs is analogous.
  - tft_rgb = selected pixel when data_req was 1, else 0.
- Pixel selection:
  - mode 0: data_in.
  - mode 1: 8 vertical bars, bar index = pix_x*8/H_ACTIVE (integer). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 2: (pix_x[5] XOR pix_y[5]) ? FFFF : 0000.
  - mode 3: latched solid_color.
- Idle levels, also the reset values: tft_hs = ~HS_POL, tft_vs = ~VS_POL, tft_de = 0, tft_rgb = 0, tft_bl = 0, data_req = 0, pulses = 0.
- Reset mid-frame: everything returns to idle immediately, asynchronously. No partial output after release until en restarts.
- Counter widths must cover H_TOTAL-1 and V_TOTAL-1. This is a static assertion: CNT_W too small is a configuration error.

Test Plan:
- Reset, en = 1, mode 0, data_in = pix_x -> first tft_de rise at h_cnt = 217 (one cycle after data_req at 216) on v_cnt = 35. 800 DE cycles per line; first tft_rgb = 0, last = 799.
- Full frame count -> line period 1056 cycles. Frame period 1056*525 = 554400 cycles. HS low exactly 128 cycles, VS low exactly 2 lines. frame_start once per frame.
- HS_POL = 1, VS_POL = 1 build -> syncs high during pulses, low at idle and after reset.
- mode 1 -> pix_x 0..99 yields FFFF, 100..199 yields FFE0, 700..799 yields 0000. mode 2 -> (32,0) = FFFF, (32,32) = 0000.
- Change mode 0 -> 3 with solid_color = F800 mid-frame -> current frame stays pass-through. The next frame is all F800 in the active area.
- Drop en mid-frame -> frame completes to h = 1055, v = 524, then outputs idle and tft_bl = 0. Assert rst_n low mid-line -> same cycle, all outputs idle.
